// File: rtl/mmc_pkg.sv
// Shared definitions for the MMC read-path blocks.
//   mmc_pk_state_e : packer FSM state encoding (IDLE / ACTIVE / FLUSH)
//   MMC_WORD_W     : width of a host-side data word
package mmc_pkg;

    localparam int MMC_WORD_W = 32;

    typedef enum logic [1:0] {
        MMC_PK_IDLE   = 2'd0,
        MMC_PK_ACTIVE = 2'd1,
        MMC_PK_FLUSH  = 2'd2
    } mmc_pk_state_e;

endpackage : mmc_pkg

// File: rtl/mmc_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   flush_i        : empty the FIFO (pointers and level to zero), wins over push/pop
//   push_i, push_data_i : write request and word
//   pop_i          : take the head word; ignored while empty
//   rd_data_o      : head word (mem[rd_ptr]), meaningful only while valid_o
//   valid_o        : FIFO not empty
//   level_o        : number of words held (0..DEPTH)
//   full_o         : level_o == DEPTH
// A push while full succeeds only if a pop happens in the same cycle;
// otherwise the word is silently dropped (the caller detects that case).
module mmc_sync_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int WIDTH  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [WIDTH-1:0]  push_data_i,
    input  logic              pop_i,
    output logic [WIDTH-1:0]  rd_data_o,
    output logic              valid_o,
    output logic [ADDR_W:0]   level_o,
    output logic              full_o
);

    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W:0]   level_reg;
    logic              pop_ok;
    logic              push_ok;

    assign valid_o   = (level_reg != '0);
    assign full_o    = (level_reg == FULL_LEVEL);
    assign level_o   = level_reg;
    assign rd_data_o = mem[rd_ptr_reg];

    assign pop_ok  = pop_i & valid_o;
    // A pop frees the slot in the same cycle, so a full FIFO can still take a word.
    assign push_ok = push_i & (~full_o | pop_ok);

    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) begin
            mem[wr_ptr_reg] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule : mmc_sync_fifo

// File: rtl/mmc_dat_rx_packer.sv
// Packs the MMC DAT deserialiser byte stream little-endian into 32-bit words
// and buffers them in a FWFT FIFO for the host-side data port.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   start_i                 : begin a read transfer (honoured in IDLE only)
//   abort_i                 : abandon transfer, empty FIFO (highest priority)
//   in_valid_i, in_data_i   : byte stream from the deserialiser
//   in_complete_i           : last block finished
//   out_valid_o, out_data_o : head word of the FIFO
//   out_accept_i            : consumer takes the head word
//   level_o                 : words held in the FIFO
//   overflow_o              : sticky, a word was dropped on a full FIFO
//   done_o                  : one-cycle pulse, transfer fully written to the FIFO
module mmc_dat_rx_packer
    import mmc_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic                  in_valid_i,
    input  logic [7:0]            in_data_i,
    input  logic                  in_complete_i,
    output logic                  out_valid_o,
    output logic [MMC_WORD_W-1:0] out_data_o,
    input  logic                  out_accept_i,
    output logic [ADDR_W:0]       level_o,
    output logic                  overflow_o,
    output logic                  done_o
);

    mmc_pk_state_e         state_reg;
    logic [1:0]            byte_cnt_reg;
    logic [MMC_WORD_W-1:0] partial_reg;
    logic                  overflow_reg;
    logic                  done_reg;

    logic                  push_next;
    logic [MMC_WORD_W-1:0] push_data_next;
    logic                  pop;
    logic                  fifo_full;
    logic                  drop;

    assign overflow_o = overflow_reg;
    assign done_o     = done_reg;
    assign pop        = out_valid_o & out_accept_i;
    assign drop       = push_next & fifo_full & ~pop;

    // Push decision. The partial word is cleared after every full-word push,
    // so in FLUSH its unused upper lanes are already zero.
    always_comb begin
        push_next      = 1'b0;
        push_data_next = partial_reg;
        if (!abort_i) begin
            if (state_reg == MMC_PK_ACTIVE && in_valid_i && byte_cnt_reg == 2'd3) begin
                push_next      = 1'b1;
                push_data_next = {in_data_i, partial_reg[23:0]};
            end else if (state_reg == MMC_PK_FLUSH && byte_cnt_reg != 2'd0) begin
                push_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= MMC_PK_IDLE;
            byte_cnt_reg <= 2'd0;
            partial_reg  <= '0;
            overflow_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (abort_i) begin
                state_reg    <= MMC_PK_IDLE;
                byte_cnt_reg <= 2'd0;
                partial_reg  <= '0;
                overflow_reg <= 1'b0;
            end else begin
                if (drop) begin
                    overflow_reg <= 1'b1;
                end
                case (state_reg)
                    MMC_PK_IDLE: begin
                        if (start_i) begin
                            state_reg    <= MMC_PK_ACTIVE;
                            byte_cnt_reg <= 2'd0;
                            partial_reg  <= '0;
                            overflow_reg <= 1'b0;
                        end
                    end
                    MMC_PK_ACTIVE: begin
                        if (in_valid_i) begin
                            if (byte_cnt_reg == 2'd3) begin
                                partial_reg <= '0;
                            end else begin
                                partial_reg[{byte_cnt_reg, 3'b000} +: 8] <= in_data_i;
                            end
                            byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        end
                        // The coincident byte above is taken before leaving ACTIVE.
                        if (in_complete_i) begin
                            state_reg <= MMC_PK_FLUSH;
                        end
                    end
                    MMC_PK_FLUSH: begin
                        state_reg    <= MMC_PK_IDLE;
                        byte_cnt_reg <= 2'd0;
                        partial_reg  <= '0;
                        done_reg     <= 1'b1;
                    end
                    default: begin
                        state_reg <= MMC_PK_IDLE;
                    end
                endcase
            end
        end
    end

    mmc_sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (MMC_WORD_W)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (abort_i),
        .push_i      (push_next),
        .push_data_i (push_data_next),
        .pop_i       (pop),
        .rd_data_o   (out_data_o),
        .valid_o     (out_valid_o),
        .level_o     (level_o),
        .full_o      (fifo_full)
    );

endmodule : mmc_dat_rx_packer

// File: tb/tb_mmc_dat_rx_packer.sv
// Directed self-checking bench for mmc_dat_rx_packer.
module tb_mmc_dat_rx_packer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        abort_i;
    logic        in_valid_i;
    logic [7:0]  in_data_i;
    logic        in_complete_i;
    logic        out_valid_o;
    logic [31:0] out_data_o;
    logic        out_accept_i;
    logic [3:0]  level_o;
    logic        overflow_o;
    logic        done_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    mmc_dat_rx_packer #(.DEPTH(8), .ADDR_W(3)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .in_valid_i    (in_valid_i),
        .in_data_i     (in_data_i),
        .in_complete_i (in_complete_i),
        .out_valid_o   (out_valid_o),
        .out_data_o    (out_data_o),
        .out_accept_i  (out_accept_i),
        .level_o       (level_o),
        .overflow_o    (overflow_o),
        .done_o        (done_o)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // One clock; afterwards outputs reflect the edge just taken.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic cmp);
        in_valid_i    = 1'b1;
        in_data_i     = d;
        in_complete_i = cmp;
        step();
        in_valid_i    = 1'b0;
        in_complete_i = 1'b0;
    endtask

    task automatic pulse_complete();
        in_complete_i = 1'b1;
        step();
        in_complete_i = 1'b0;
    endtask

    task automatic pop_one();
        out_accept_i = 1'b1;
        step();
        out_accept_i = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_w;
        rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; in_valid_i = 1'b0;
        in_data_i = 8'h00; in_complete_i = 1'b0; out_accept_i = 1'b0;
        step(); step();
        rst_i = 1'b0;
        step();
        check_val("rst_valid", {31'd0, out_valid_o}, 32'd0);
        check_val("rst_level", {28'd0, level_o}, 32'd0);
        check_val("rst_ovf", {31'd0, overflow_o}, 32'd0);
        check_val("rst_done", {31'd0, done_o}, 32'd0);

        // Aligned packing
        pulse_start();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        check_val("align_not_yet", {31'd0, out_valid_o}, 32'd0);
        send_byte(8'h44, 1'b0);
        check_val("align_valid", {31'd0, out_valid_o}, 32'd1);
        check_val("align_data", out_data_o, 32'h44332211);
        check_val("align_level", {28'd0, level_o}, 32'd1);
        pop_one();
        check_val("align_pop_level", {28'd0, level_o}, 32'd0);
        check_val("align_pop_valid", {31'd0, out_valid_o}, 32'd0);
        pulse_complete();
        step();

        // Partial flush
        pulse_start();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        pulse_complete();
        check_val("part_done_early", {31'd0, done_o}, 32'd0);
        check_val("part_level_early", {28'd0, level_o}, 32'd0);
        step();
        check_val("part_done", {31'd0, done_o}, 32'd1);
        check_val("part_level", {28'd0, level_o}, 32'd1);
        check_val("part_data", out_data_o, 32'h0000BBAA);
        step();
        check_val("part_done_1cyc", {31'd0, done_o}, 32'd0);
        // Back in IDLE: bytes are ignored
        for (int i = 0; i < 4; i++) send_byte(8'hEE, 1'b0);
        check_val("idle_ignore_lvl", {28'd0, level_o}, 32'd1);
        pop_one();

        // Coincident last byte and complete
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b1);
        check_val("coin_data", out_data_o, 32'h04030201);
        check_val("coin_level", {28'd0, level_o}, 32'd1);
        step();
        check_val("coin_done", {31'd0, done_o}, 32'd1);
        check_val("coin_no_pad", {28'd0, level_o}, 32'd1);
        pop_one();
        check_val("coin_empty", {28'd0, level_o}, 32'd0);

        // Overflow: 36 bytes, nothing accepted
        pulse_start();
        for (int k = 0; k < 36; k++) send_byte(8'(k), 1'b0);
        check_val("ovf_level", {28'd0, level_o}, 32'd8);
        check_val("ovf_flag", {31'd0, overflow_o}, 32'd1);
        pulse_complete();
        step();
        for (int w = 0; w < 8; w++) begin
            exp_w = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
            check_val($sformatf("ovf_drain%0d", w), out_data_o, exp_w);
            pop_one();
        end
        check_val("ovf_no_9th", {31'd0, out_valid_o}, 32'd0);
        check_val("ovf_sticky", {31'd0, overflow_o}, 32'd1);

        // Full with simultaneous pop
        pulse_start();
        check_val("start_clr_ovf", {31'd0, overflow_o}, 32'd0);
        for (int k = 0; k < 35; k++) send_byte(8'(8'h80 + k), 1'b0);
        check_val("fp_full", {28'd0, level_o}, 32'd8);
        out_accept_i = 1'b1;
        send_byte(8'(8'h80 + 35), 1'b0);
        out_accept_i = 1'b0;
        check_val("fp_level", {28'd0, level_o}, 32'd8);
        check_val("fp_ovf", {31'd0, overflow_o}, 32'd0);
        check_val("fp_head", out_data_o, 32'h87868584);

        // Abort mid-word with 3 words held
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        check_val("abort_clr_lvl", {28'd0, level_o}, 32'd0);
        pulse_start();
        for (int k = 0; k < 12; k++) send_byte(8'(8'h40 + k), 1'b0);
        check_val("ab_level3", {28'd0, level_o}, 32'd3);
        send_byte(8'h50, 1'b0);
        send_byte(8'h51, 1'b0);
        abort_i = 1'b1;
        send_byte(8'h52, 1'b1);
        abort_i = 1'b0;
        check_val("ab_level", {28'd0, level_o}, 32'd0);
        check_val("ab_valid", {31'd0, out_valid_o}, 32'd0);
        check_val("ab_done0", {31'd0, done_o}, 32'd0);
        step();
        check_val("ab_done1", {31'd0, done_o}, 32'd0);
        check_val("ab_level_stay", {28'd0, level_o}, 32'd0);
        pulse_start();
        send_byte(8'h05, 1'b0);
        send_byte(8'h06, 1'b0);
        send_byte(8'h07, 1'b0);
        send_byte(8'h08, 1'b0);
        check_val("ab_clean_data", out_data_o, 32'h08070605);
        check_val("ab_clean_lvl", {28'd0, level_o}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mmc_dat_rx_packer
